dct_coef_engine: RTL and testbench
==================================

DCT_COEF_ENGINE -- requirements
Module: dct_coef_engine

Interface
REQ-001 Parameter: DATA_W, default 8, signed sample width.
REQ-002 Parameter: N_PTS, default 8, transform length; legal values are 4, 8 and 16.
REQ-003 Parameter: COEF_W, default 16, signed coefficient width, Q2.(COEF_W-2).
REQ-004 Parameter: OUT_W, default 19, signed result width.
REQ-005 Parameter: FRAC_SH, default 14, right shift applied to the accumulator before output.
REQ-006 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-007 Port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 Port: en  in  1  clock enable; while low, all state holds.
REQ-009 Port: in_valid  in  1  frame offered.
REQ-010 Port: in_ready  out  1  engine can accept a frame.
REQ-011 Port: in_data  in  N_PTS*DATA_W  packed signed samples; sample n occupies bits [n*DATA_W +: DATA_W].
REQ-012 Port: k_sel  in  clog2(N_PTS)  coefficient index, sampled with the frame.
REQ-013 Port: out_valid  out  1  result available.
REQ-014 Port: out_ready  in  1  downstream accepts the result.
REQ-015 Port: out_data  out  OUT_W  signed X[k] result.
REQ-016 Port: out_k  out  clog2(N_PTS)  index that produced out_data.
REQ-017 Port: sat_flag  out  1  out_data was saturated; valid together with out_valid.
REQ-018 Port: busy  out  1  high in every state except IDLE.

Function
REQ-019 The engine SHALL compute X[k] = sum over n of x[n]*C[k][n], where C[k][n] = round(2^(COEF_W-2) * c(k) * cos((2n+1)*k*pi/(2*N_PTS))), with c(0) = sqrt(1/N) and c(k>0) = sqrt(2/N).
REQ-020 The FSM SHALL have the states IDLE, FETCH, ACC, ROUND and OUT.
REQ-021 in_ready = (state==IDLE) && en; a frame is accepted when in_valid && in_ready; accepting a frame captures in_data and k_sel and moves the FSM to FETCH.
REQ-022 FETCH SHALL issue ROM address (k, n=0) and clear the accumulator; the next state is ACC.
REQ-023 ACC SHALL perform one MAC per enabled cycle for n = 0..N_PTS-1, prefetching address n+1 to cover the 1-cycle ROM latency; after the final MAC the next state is ROUND.
REQ-024 Accumulator width SHALL be DATA_W + COEF_W + clog2(N_PTS); the accumulator SHALL NOT overflow internally.
REQ-025 ROUND SHALL add 2^(FRAC_SH-1), arithmetic-shift right by FRAC_SH, then saturate to the signed OUT_W range; sat_flag = 1 if clipping occurred.
REQ-026 ROUND SHALL register out_data, out_k and sat_flag; the next state is OUT.
REQ-027 out_valid SHALL be 1 only in OUT, exactly N_PTS+2 enabled cycles after the acceptance edge.
REQ-028 In OUT, out_data, out_k and sat_flag SHALL stay stable until out_valid && out_ready && en; the FSM then returns to IDLE.
REQ-029 Back-pressure of any length SHALL lose no data.
REQ-030 While en = 0, the FSM, counter, accumulator and registered outputs SHALL hold, and no handshake SHALL complete on either side.
REQ-031 in_valid asserted while the engine is busy SHALL be ignored; the frame is not captured.
REQ-032 Every k_sel value SHALL be legal; k = 0 selects the DC coefficient.

Reset
REQ-033 rst_n low SHALL, asynchronously and at any point (including mid-ACC or mid-OUT), force state = IDLE and zero the counter, accumulator, out_data, out_k and sat_flag, with out_valid = 0 and busy = 0.
REQ-034 While rst_n is low, in_ready SHALL be 0.
REQ-035 An aborted frame SHALL produce no output.

Structure
REQ-036 A shared package dct_pkg SHALL hold the FSM state enum, the coefficient tables for N_PTS = 4, 8 and 16 (Q2.14, COEF_W = 16), and a clog2 helper.
REQ-037 One sub-module, dct_coef_rom, SHALL hold the table: registered read, 1-cycle latency, address {k, n}, chip-select tied to the FSM fetch enable.

Verification
REQ-038 Defaults, all samples = 100, k = 0 -> out_data = 283, sat_flag = 0, out_k = 0; out_valid rises 10 cycles after accept.
REQ-039 All samples = 100, k = 1..7 -> out_data = 0 for each k.
REQ-040 Samples x[n] = (-1)^n * 127, k = 7, OUT_W = 8 -> out_data = 127, sat_flag = 1.
REQ-041 out_ready held low for 20 cycles -> out_data stable, in_ready = 0, then one transfer, then return to IDLE.
REQ-042 en low for 3 cycles mid-ACC -> result identical to the uninterrupted run, with latency extended by 3.
REQ-043 rst_n pulsed during ACC -> all outputs 0 immediately; a fresh frame afterwards is correct.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and coefficient tables for the DCT coefficient engine.
// Tables are Q2.14 quarter-wave magnitudes; coef_val() unfolds them into C[k][n].
package dct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACC,
    ST_ROUND,
    ST_OUT
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // round(2^14 * sqrt(2/N) * cos(m*pi/(2N))) for m = 0..N
  function automatic int quarter_wave(input int n_pts, input int m);
    int v;
    v = 0;
    if (n_pts == 4) begin
      case (m)
        0: v = 11585; 1: v = 10703; 2: v = 8192; 3: v = 4433;
        default: v = 0;
      endcase
    end else if (n_pts == 8) begin
      case (m)
        0: v = 8192; 1: v = 8035; 2: v = 7568; 3: v = 6811;
        4: v = 5793; 5: v = 4551; 6: v = 3135; 7: v = 1598;
        default: v = 0;
      endcase
    end else begin
      case (m)
        0:  v = 5793; 1:  v = 5765; 2:  v = 5681; 3:  v = 5543;
        4:  v = 5352; 5:  v = 5109; 6:  v = 4816; 7:  v = 4478;
        8:  v = 4096; 9:  v = 3675; 10: v = 3218; 11: v = 2731;
        12: v = 2217; 13: v = 1682; 14: v = 1130; 15: v = 568;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  // Angle (2n+1)k*pi/(2N) folded into the first quadrant with sign.
  function automatic int coef_val(input int n_pts, input int k, input int n);
    int m;
    int v;
    if (k == 0) begin
      v = (n_pts == 4) ? 8192 : (n_pts == 8) ? 5793 : 4096;
    end else begin
      m = ((2 * n + 1) * k) % (4 * n_pts);
      if (m > 2 * n_pts) m = 4 * n_pts - m;
      if (m > n_pts) v = -quarter_wave(n_pts, 2 * n_pts - m);
      else           v = quarter_wave(n_pts, m);
    end
    return v;
  endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Coefficient ROM: registered read with one cycle of latency, address {k, n}.
module dct_coef_rom import dct_pkg::*; #(
  parameter int N_PTS  = 8,
  parameter int COEF_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic [2*clog2(N_PTS)-1:0]     addr,
  output logic [COEF_W-1:0]             coef
);

  logic [COEF_W-1:0] table_w [N_PTS*N_PTS];

  for (genvar i = 0; i < N_PTS * N_PTS; i++) begin : g_tab
    assign table_w[i] = COEF_W'(coef_val(N_PTS, i / N_PTS, i % N_PTS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  coef <= '0;
    else if (cs) coef <= table_w[addr];
  end

endmodule

// File: rtl/dct_coef_engine.sv
// Single-coefficient DCT engine: X[k] = sum x[n]*C[k][n], one MAC per cycle.
//   state    | meaning
//   IDLE     | waiting for a frame, in_ready high when enabled
//   FETCH    | issue ROM address (k,0), clear accumulator
//   ACC      | MAC sample idx, prefetch coefficient idx+1
//   ROUND    | round, shift, saturate, register outputs
//   OUT      | hold result until out_ready
module dct_coef_engine import dct_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int N_PTS   = 8,
  parameter int COEF_W  = 16,
  parameter int OUT_W   = 19,
  parameter int FRAC_SH = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_PTS*DATA_W-1:0]    in_data,
  input  logic [clog2(N_PTS)-1:0]    k_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [clog2(N_PTS)-1:0]    out_k,
  output logic                       sat_flag,
  output logic                       busy
);

  localparam int KW    = clog2(N_PTS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + KW;
  localparam int RW    = ACC_W + 1;

  state_t state, state_nxt;

  logic [N_PTS*DATA_W-1:0] frame;
  logic [KW-1:0]           k_reg, idx, n_addr;
  logic                    accept, last_mac, rom_cs, ovf;
  logic [2*KW-1:0]         rom_addr;
  logic [COEF_W-1:0]       coef;
  logic signed [DATA_W-1:0] sample;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc, prod_ext;
  logic signed [RW-1:0]    rounded, shifted;
  logic [OUT_W-1:0]        sat_val;

  assign in_ready  = (state == ST_IDLE) && en && rst_n;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign last_mac  = (idx == KW'(N_PTS - 1));

  // ROM is one cycle behind, so ACC always reads the coefficient for the next sample.
  assign rom_cs   = en && ((state == ST_FETCH) || ((state == ST_ACC) && !last_mac));
  assign n_addr   = (state == ST_FETCH) ? KW'(0) : idx + 1'b1;
  assign rom_addr = {k_reg, n_addr};

  dct_coef_rom #(.N_PTS(N_PTS), .COEF_W(COEF_W)) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (rom_cs),
    .addr  (rom_addr),
    .coef  (coef)
  );

  assign sample   = frame[idx*DATA_W +: DATA_W];
  assign prod     = sample * $signed(coef);
  assign prod_ext = {{KW{prod[PW-1]}}, prod};

  assign rounded = {acc[ACC_W-1], acc} + (RW'(1) << (FRAC_SH - 1));
  assign shifted = rounded >>> FRAC_SH;
  assign ovf     = !((&shifted[RW-1:OUT_W-1]) || !(|shifted[RW-1:OUT_W-1]));
  assign sat_val = shifted[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_ACC;
      ST_ACC:   if (last_mac) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= ST_IDLE;
    else if (en) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '0;
      k_reg    <= '0;
      idx      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_k    <= '0;
      sat_flag <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: if (accept) begin
          frame <= in_data;
          k_reg <= k_sel;
        end
        ST_FETCH: begin
          idx <= '0;
          acc <= '0;
        end
        ST_ACC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        ST_ROUND: begin
          out_data <= ovf ? sat_val : shifted[OUT_W-1:0];
          out_k    <= k_reg;
          sat_flag <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_coef_engine.sv
// Scoreboard bench: two engines (OUT_W=19 and OUT_W=8) driven in lockstep.
module tb_dct_coef_engine;
  localparam int N  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [2:0]    k_sel = '0;

  logic          in_ready, out_valid, sat_flag, busy;
  logic [18:0]   out_data;
  logic [2:0]    out_k;
  logic          in_ready8, out_valid8, sat_flag8, busy8;
  logic [7:0]    out_data8;
  logic [2:0]    out_k8;

  dct_coef_engine dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .k_sel(k_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_k(out_k), .sat_flag(sat_flag), .busy(busy)
  );

  dct_coef_engine #(.OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .k_sel(k_sel), .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .out_k(out_k8), .sat_flag(sat_flag8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int   data;
    logic sat;
    int   data8;
    logic sat8;
    int   k;
    int   lat;
    int   acc_cyc;
  } exp_t;

  exp_t q[$];
  logic seen = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clip(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // mode 0: all v, 1: +v/-v alternating, 2: ramp x[n]=n, 3: impulse x[0]=v
  function automatic logic [N*DW-1:0] mk(input int mode, input int v);
    logic [N*DW-1:0] f;
    f = '0;
    for (int n = 0; n < N; n++) begin
      int s;
      case (mode)
        0:       s = v;
        1:       s = (n % 2 == 1) ? -v : v;
        2:       s = n;
        default: s = (n == 0) ? v : 0;
      endcase
      f[n*DW +: DW] = DW'(s);
    end
    return f;
  endfunction

  task automatic send(input logic [N*DW-1:0] f, input int k, input int val, input int extra);
    exp_t e;
    @(posedge clk); #1;
    in_data  = f;
    k_sel    = 3'(k);
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data    = clip(val, 19);
        e.sat     = (clip(val, 19) != val);
        e.data8   = clip(val, 8);
        e.sat8    = (clip(val, 8) != val);
        e.k       = k;
        e.lat     = N + 2 + extra;
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL accept_timeout: in_ready never rose for k=%0d, expected acceptance", k);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
      seen = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out: out_valid=1 with out_data=%0d, expected no result", $signed(out_data));
      end else begin
        if (!seen) begin
          check("latency", cyc - q[0].acc_cyc, q[0].lat);
          seen = 1'b1;
        end
        check("out_data", $signed(out_data), q[0].data);
        check("sat_flag", sat_flag, q[0].sat);
        check("out_k", out_k, q[0].k);
        check("out_data_w8", $signed(out_data8), q[0].data8);
        check("sat_flag_w8", sat_flag8, q[0].sat8);
        check("out_valid_w8", out_valid8, 1);
        check("in_ready_in_out", in_ready, 0);
        if (out_ready && en) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_flag", sat_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    // DC of a flat frame, then every AC bin of it (back-to-back offers)
    send(mk(0, 100), 0, 283, 0);
    drain();
    for (int k = 1; k < 8; k++) send(mk(0, 100), k, 0, 0);
    drain();

    send(mk(1, 127), 7, 325, 0);
    send(mk(2, 0), 0, 10, 0);
    send(mk(3, 127), 1, 62, 0);
    send(mk(0, -128), 0, -362, 0);
    drain();

    // back-pressure: 20+ cycles with out_ready low
    out_ready = 1'b0;
    send(mk(0, 100), 0, 283, 0);
    repeat (30) @(posedge clk);
    #1;
    check("bp_held_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);
    check("bp_after_busy", busy, 0);

    // clock-enable gap of 3 cycles mid-ACC
    send(mk(1, 127), 7, 325, 3);
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("en_low_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    drain();

    // asynchronous reset mid-ACC aborts the frame
    send(mk(2, 0), 0, 10, 0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_k", out_k, 0);
    check("abort_sat_flag", sat_flag, 0);
    check("abort_out_data_w8", out_data8, 0);
    q.delete();
    seen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(mk(0, -128), 0, -362, 0);
    drain();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
    $fatal(1);
  end

endmodule
